// File: rtl/cpu_reg_package.sv
// Shared definitions for the CPU bus fabric: slave address map, FSM state type
// and the default slave count.
package cpu_reg_package;

    localparam int unsigned num_entries  = 8;
    localparam int unsigned MapAddrWidth = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } bus_state_t;

    // Slave identifiers; index k of slv_sel_o corresponds to enum value k.
    typedef enum logic [4:0] {
        Slave0 = 5'd0,
        Slave1 = 5'd1,
        Slave2 = 5'd2,
        Slave3 = 5'd3,
        Slave4 = 5'd4,
        Slave5 = 5'd5,
        Slave6 = 5'd6,
        Slave7 = 5'd7
    } slave_e;

    // Slaves 1 and 3 overlap at 0x2000-0x2FFF; the decoder resolves to the lower index.
    function automatic logic [MapAddrWidth-1:0] get_address_start(input slave_e slv);
        case (slv)
            Slave0:  return 32'h0000_0000;
            Slave1:  return 32'h0000_2000;
            Slave2:  return 32'h0000_1000;
            Slave3:  return 32'h0000_2000;
            Slave4:  return 32'h0000_4000;
            Slave5:  return 32'h0000_5000;
            Slave6:  return 32'h0000_6000;
            Slave7:  return 32'h0000_7000;
            // Unmapped slots get an empty range (start > end) so they never match.
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [MapAddrWidth-1:0] get_address_end(input slave_e slv);
        case (slv)
            Slave0:  return 32'h0000_0FFF;
            Slave1:  return 32'h0000_2FFF;
            Slave2:  return 32'h0000_1FFF;
            Slave3:  return 32'h0000_3FFF;
            Slave4:  return 32'h0000_4FFF;
            Slave5:  return 32'h0000_5FFF;
            Slave6:  return 32'h0000_6FFF;
            Slave7:  return 32'h0000_7FFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/reset_stretcher.sv
// Holds reset_o high for RESET_STRETCH clocks after reset_i releases.
// Synchronous active-low reset_i restarts the count every time it is low.
module reset_stretcher #(
    parameter int unsigned RESET_STRETCH = 5
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic reset_o
);

    localparam int unsigned CntW = $clog2(RESET_STRETCH + 1);

    logic [CntW-1:0] cnt_q;
    logic            reset_q;

    if (RESET_STRETCH < 1) begin : g_bad_stretch
        $error("RESET_STRETCH must be at least 1");
    end

    // Count clocks with reset_i high; drop reset_o once the count is reached.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q   <= '0;
            reset_q <= 1'b1;
        end else if (reset_q) begin
            if (cnt_q == CntW'(RESET_STRETCH)) begin
                reset_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign reset_o = reset_q;

endmodule

// File: rtl/cpu_bus_fabric.sv
// Single-master CPU bus fabric: decodes a CPU access onto one of NUM_SLAVES
// slave channels, waits for that slave's ready and returns a one-cycle response.
// Optional build macro BUS_TIMEOUT_EN adds an ACCESS wait-cycle limit that ends
// the access with an error after TIMEOUT_CYCLES cycles without slave ready.
module cpu_bus_fabric
    import cpu_reg_package::*;
#(
    parameter int unsigned NUM_SLAVES     = num_entries,
    parameter int unsigned address_width  = 32,
    parameter int unsigned data_width     = 32,
    parameter int unsigned RESET_STRETCH  = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  cpu_req_i,
    input  logic                                  cpu_we_i,
    input  logic [address_width-1:0]              cpu_addr_i,
    input  logic [data_width-1:0]                 cpu_wdata_i,
    input  logic [data_width/8-1:0]               cpu_be_i,
    output logic [data_width-1:0]                 cpu_rdata_o,
    output logic                                  cpu_ready_o,
    output logic                                  cpu_err_o,
    output logic [NUM_SLAVES-1:0]                 slv_sel_o,
    output logic [address_width-1:0]              slv_addr_o,
    output logic [data_width-1:0]                 slv_wdata_o,
    output logic [data_width/8-1:0]               slv_be_o,
    output logic                                  slv_we_o,
    input  logic [NUM_SLAVES-1:0][data_width-1:0] slv_rdata_i,
    input  logic [NUM_SLAVES-1:0]                 slv_ready_i,
    output logic                                  cpu_reset_o
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 32) begin : g_bad_num_slaves
        $error("NUM_SLAVES must be in 1..32");
    end
    if (data_width % 8 != 0) begin : g_bad_data_width
        $error("data_width must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    bus_state_t                 state_q;
    logic [NUM_SLAVES-1:0]      slv_sel_q;
    logic [address_width-1:0]   slv_addr_q;
    logic [data_width-1:0]      slv_wdata_q;
    logic [data_width/8-1:0]    slv_be_q;
    logic                       slv_we_q;
    logic [data_width-1:0]      cpu_rdata_q;
    logic                       cpu_ready_q;
    logic                       cpu_err_q;

    logic [NUM_SLAVES-1:0]      hit_vec;
    logic [NUM_SLAVES-1:0]      dec_onehot;
    logic [63:0]                addr_ext;
    logic                       sel_ready;
    logic [data_width-1:0]      sel_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TimeoutW-1:0] wait_cnt_q;
`endif

    reset_stretcher #(
        .RESET_STRETCH (RESET_STRETCH)
    ) u_reset_stretcher (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .reset_o (cpu_reset_o)
    );

    // Address decode: flag every slave whose inclusive range covers the address.
    always_comb begin
        hit_vec  = '0;
        addr_ext = 64'(cpu_addr_i);
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            hit_vec[k] = (addr_ext >= 64'(get_address_start(slave_e'(5'(k))))) &&
                         (addr_ext <= 64'(get_address_end(slave_e'(5'(k)))));
        end
    end

    // Isolate the lowest set bit so overlapping ranges resolve to the lowest index.
    assign dec_onehot = hit_vec & (~hit_vec + NUM_SLAVES'(1));

    // Route only the selected slave's ready and read data; others are masked off.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            if (slv_sel_q[k]) begin
                sel_ready = sel_ready | slv_ready_i[k];
                sel_rdata = sel_rdata | slv_rdata_i[k];
            end
        end
    end

    // Bus FSM with registered outputs: IDLE -> ACCESS -> RESP, or IDLE -> RESP on miss.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            slv_sel_q   <= '0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
            slv_be_q    <= '0;
            slv_we_q    <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_req_i && !cpu_reset_o) begin
                        slv_addr_q  <= cpu_addr_i;
                        slv_wdata_q <= cpu_wdata_i;
                        slv_be_q    <= cpu_be_i;
                        slv_we_q    <= cpu_we_i;
                        if (|hit_vec) begin
                            slv_sel_q <= dec_onehot;
                            state_q   <= ACCESS;
`ifdef BUS_TIMEOUT_EN
                            wait_cnt_q <= '0;
`endif
                        end else begin
                            state_q     <= RESP;
                            cpu_ready_q <= 1'b1;
                            cpu_err_q   <= 1'b1;
                            cpu_rdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        slv_sel_q   <= '0;
                        state_q     <= RESP;
                        cpu_ready_q <= 1'b1;
                        cpu_rdata_q <= slv_we_q ? '0 : sel_rdata;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (wait_cnt_q == TimeoutW'(TIMEOUT_CYCLES)) begin
                        slv_sel_q   <= '0;
                        state_q     <= RESP;
                        cpu_ready_q <= 1'b1;
                        cpu_err_q   <= 1'b1;
                        cpu_rdata_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TimeoutW'(1);
                    end
`endif
                end
                RESP: begin
                    // The response cycle never accepts a new request.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign slv_sel_o   = slv_sel_q;
    assign slv_addr_o  = slv_addr_q;
    assign slv_wdata_o = slv_wdata_q;
    assign slv_be_o    = slv_be_q;
    assign slv_we_o    = slv_we_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ready_o = cpu_ready_q;
    assign cpu_err_o   = cpu_err_q;

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Scoreboard bench for cpu_bus_fabric: drivers push expected responses, a
// monitor pops and compares them whenever cpu_ready_o is seen.
module tb_cpu_bus_fabric;

    localparam int NS = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RS = 5;
    localparam int TC = 16;

    logic                  clk_i = 1'b0;
    logic                  reset_i;
    logic                  cpu_req_i;
    logic                  cpu_we_i;
    logic [AW-1:0]         cpu_addr_i;
    logic [DW-1:0]         cpu_wdata_i;
    logic [DW/8-1:0]       cpu_be_i;
    logic [DW-1:0]         cpu_rdata_o;
    logic                  cpu_ready_o;
    logic                  cpu_err_o;
    logic [NS-1:0]         slv_sel_o;
    logic [AW-1:0]         slv_addr_o;
    logic [DW-1:0]         slv_wdata_o;
    logic [DW/8-1:0]       slv_be_o;
    logic                  slv_we_o;
    logic [NS-1:0][DW-1:0] slv_rdata_i;
    logic [NS-1:0]         slv_ready_i;
    logic                  cpu_reset_o;

    cpu_bus_fabric #(
        .NUM_SLAVES     (NS),
        .address_width  (AW),
        .data_width     (DW),
        .RESET_STRETCH  (RS),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_be_i    (cpu_be_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_ready_o (cpu_ready_o),
        .cpu_err_o   (cpu_err_o),
        .slv_sel_o   (slv_sel_o),
        .slv_addr_o  (slv_addr_o),
        .slv_wdata_o (slv_wdata_o),
        .slv_be_o    (slv_be_o),
        .slv_we_o    (slv_we_o),
        .slv_rdata_i (slv_rdata_i),
        .slv_ready_i (slv_ready_i),
        .cpu_reset_o (cpu_reset_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   resp_seen = 0;
    int   cyc = 0;

    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every cpu_ready_o pulse must match the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (cpu_ready_o === 1'b1) begin
                resp_seen++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ready: cpu_ready_o=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_rdata", 64'(cpu_rdata_o), 64'(e.rdata));
                    check("resp_err", 64'(cpu_err_o), 64'(e.err));
                    check("resp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Pull reset low for one cycle, check reset values, then the stretch length.
    task automatic reset_and_stretch(input string name);
        reset_i = 1'b0;
        @(negedge clk_i);
        check({name, "_rst_sel"}, 64'(slv_sel_o), 64'd0);
        check({name, "_rst_ready"}, 64'(cpu_ready_o), 64'd0);
        check({name, "_rst_err"}, 64'(cpu_err_o), 64'd0);
        check({name, "_rst_rdata"}, 64'(cpu_rdata_o), 64'd0);
        check({name, "_rst_we"}, 64'(slv_we_o), 64'd0);
        check({name, "_rst_cpu_reset"}, 64'(cpu_reset_o), 64'd1);
        reset_i = 1'b1;
        for (int i = 0; i < RS; i++) begin
            @(negedge clk_i);
            check({name, "_stretch_hi"}, 64'(cpu_reset_o), 64'd1);
        end
        @(negedge clk_i);
        check({name, "_stretch_lo"}, 64'(cpu_reset_o), 64'd0);
    endtask

    // One access. k: target slave (-1 none), dly: ready delay (-1 never),
    // lat: cycles from issue to visible cpu_ready_o.
    task automatic do_access(input string name, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] b, input int k,
                             input int dly, input logic [7:0] exp_sel, input int lat,
                             input logic [31:0] exp_rd, input logic exp_err,
                             input logic drop_early);
        exp_t e;
        int   c;
        int   n;
        int   sel_cycles;
        bit   done;
        @(negedge clk_i);
        c           = cyc;
        cpu_req_i   = 1'b1;
        cpu_we_i    = w;
        cpu_addr_i  = a;
        cpu_wdata_i = d;
        cpu_be_i    = b;
        slv_ready_i = '1;
        if (k >= 0) slv_ready_i[k] = (dly == 0);
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = c + lat;
        exp_q.push_back(e);
        n          = 0;
        sel_cycles = 0;
        done       = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk_i);
            n++;
            if (slv_sel_o != '0) sel_cycles++;
            if (n == 1 && exp_sel != '0) begin
                check({name, "_sel"}, 64'(slv_sel_o), 64'(exp_sel));
                check({name, "_we"}, 64'(slv_we_o), 64'(w));
                check({name, "_be"}, 64'(slv_be_o), 64'(b));
                check({name, "_addr"}, 64'(slv_addr_o), 64'(a));
                check({name, "_wdata"}, 64'(slv_wdata_o), 64'(d));
            end
            if (n == lat - 1 && n > 1 && exp_sel != '0) begin
                check({name, "_sel_late"}, 64'(slv_sel_o), 64'(exp_sel));
                check({name, "_we_late"}, 64'(slv_we_o), 64'(w));
                check({name, "_be_late"}, 64'(slv_be_o), 64'(b));
            end
            if (drop_early && n == 1) cpu_req_i = 1'b0;
            if (dly > 0 && k >= 0 && n == dly + 1) slv_ready_i[k] = 1'b1;
            if (cpu_ready_o === 1'b1) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_wait: no cpu_ready_o in %0d cycles, required one", name, n);
        end
        cpu_req_i = 1'b0;
        check({name, "_sel_cycles"}, 64'(sel_cycles), 64'((exp_sel == '0) ? 0 : lat - 1));
    endtask

    initial begin
        int c;
        int n;
        int got;
        int r0;
        exp_t e;
        reset_i     = 1'b0;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = '0;
        cpu_wdata_i = '0;
        cpu_be_i    = '0;
        slv_ready_i = '0;
        for (int j = 0; j < NS; j++) slv_rdata_i[j] = 32'hA000_0000 | 32'(j);
        slv_rdata_i[2] = 32'hDEAD_BEEF;

        repeat (2) @(negedge clk_i);
        reset_and_stretch("por");

        do_access("read_s2", 1'b0, 32'h0000_1004, 32'h0, 4'h0, 2, 0, 8'h04, 2,
                  32'hDEAD_BEEF, 1'b0, 1'b0);
        repeat (3) @(negedge clk_i);
        check("rdata_hold", 64'(cpu_rdata_o), 64'h0000_0000_DEAD_BEEF);

        do_access("unmapped", 1'b0, 32'hFFFF_0000, 32'h0, 4'h0, -1, 0, 8'h00, 1,
                  32'h0, 1'b1, 1'b0);

        do_access("overlap", 1'b0, 32'h0000_2000, 32'h0, 4'h0, 1, 0, 8'h02, 2,
                  32'hA000_0001, 1'b0, 1'b0);

        // Request drops after acceptance; the access must still complete.
        do_access("write_s0", 1'b1, 32'h0000_0010, 32'h0000_00A5, 4'b0001, 0, 3, 8'h01, 5,
                  32'h0, 1'b0, 1'b1);

        // Request held high through RESP: second access accepted only after IDLE.
        @(negedge clk_i);
        c           = cyc;
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h0000_1008;
        slv_ready_i = '1;
        e.rdata = 32'hDEAD_BEEF;
        e.err   = 1'b0;
        e.cyc   = c + 2;
        exp_q.push_back(e);
        e.cyc   = c + 5;
        exp_q.push_back(e);
        n   = 0;
        got = 0;
        while (got < 2 && n < 50) begin
            @(negedge clk_i);
            n++;
            if (cpu_ready_o === 1'b1) got++;
        end
        cpu_req_i = 1'b0;
        check("b2b_responses", 64'(got), 64'd2);

`ifdef BUS_TIMEOUT_EN
        do_access("timeout", 1'b0, 32'h0000_5010, 32'h0, 4'h0, 5, -1, 8'h20, 18,
                  32'h0, 1'b1, 1'b0);
`else
        @(negedge clk_i);
        r0          = resp_seen;
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h0000_5010;
        slv_ready_i = '1;
        slv_ready_i[5] = 1'b0;
        repeat (1000) @(negedge clk_i);
        check("no_timeout_resp", 64'(resp_seen - r0), 64'd0);
        check("no_timeout_sel", 64'(slv_sel_o), 64'h20);
        cpu_req_i = 1'b0;
        reset_and_stretch("wait_abort");
`endif

        // Reset during ACCESS aborts silently.
        @(negedge clk_i);
        r0          = resp_seen;
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h0000_4000;
        slv_ready_i = '1;
        slv_ready_i[4] = 1'b0;
        @(negedge clk_i);
        check("midrst_sel", 64'(slv_sel_o), 64'h10);
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        reset_and_stretch("midrst");
        check("midrst_no_resp", 64'(resp_seen - r0), 64'd0);

        do_access("post_reset", 1'b0, 32'h0000_1FFC, 32'h0, 4'h0, 2, 0, 8'h04, 2,
                  32'hDEAD_BEEF, 1'b0, 1'b0);

        repeat (3) @(negedge clk_i);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_bus_fabric.md
CPU_BUS_FABRIC -- requirements
Module: cpu_bus_fabric

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 8: number of slave channels, range 1..32.
REQ-002 SHALL have parameter address_width, default 32: CPU/slave address width.
REQ-003 SHALL have parameter data_width, default 32: data width, a multiple of 8.
REQ-004 SHALL have parameter RESET_STRETCH, default 5: cycles cpu_reset_o stays high after reset_i releases, minimum 1.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum wait cycles for slave ready, minimum 2.
REQ-006 SHALL have port clk_i, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_i, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port cpu_req_i, input, 1: CPU access request, held until cpu_ready_o.
REQ-009 SHALL have port cpu_we_i, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port cpu_addr_i, input, address_width: access address.
REQ-011 SHALL have ports cpu_wdata_i (input, data_width) and cpu_be_i (input, data_width/8): write data and byte enables.
REQ-012 SHALL have ports cpu_rdata_o (output, data_width), cpu_ready_o (output, 1) and cpu_err_o (output, 1): response data, one-cycle completion pulse, and error flag qualified by cpu_ready_o.
REQ-013 SHALL have port slv_sel_o, output, NUM_SLAVES: one-hot slave select.
REQ-014 SHALL have ports slv_addr_o, slv_wdata_o, slv_be_o and slv_we_o, outputs: registered copies of the CPU request.
REQ-015 SHALL have ports slv_rdata_i (input, NUM_SLAVES x data_width) and slv_ready_i (input, NUM_SLAVES): per-slave read data and ready.
REQ-016 SHALL have port cpu_reset_o, output, 1: stretched reset to the CPU core.

Function
REQ-017 SHALL implement the state machine IDLE -> ACCESS -> RESP -> IDLE, with the direct path IDLE -> RESP for decode errors.
REQ-018 In IDLE with cpu_req_i=1 and cpu_reset_o=0, SHALL register the address, write data, byte enables and write enable, and decode the address against the package map.
- Match rule: start <= addr <= end.
- On multiple matches, the lowest index wins.
REQ-019 On no match, SHALL go to RESP with cpu_err_o=1 and cpu_rdata_o=0; no slv_sel_o bit is asserted.
REQ-020 In ACCESS, SHALL hold exactly one slv_sel_o bit high until the selected slv_ready_i is sampled high.
- On ready, capture slv_rdata_i[k] (reads only) and go to RESP.
- slv_ready_i of unselected slaves SHALL be ignored.
REQ-021 In RESP, SHALL pulse cpu_ready_o for exactly one cycle, then return to IDLE.
- Minimum latency: request sampled at cycle N, slave ready at N+1, cpu_ready_o at N+2.
REQ-022 cpu_rdata_o SHALL hold its value until the next RESP; write responses SHALL return cpu_rdata_o=0.
REQ-023 A new request SHALL NOT be accepted in the RESP cycle; back-to-back accesses take at least 3 cycles each.
REQ-024 cpu_req_i deasserting mid-access SHALL be ignored; the access completes.

Reset
REQ-025 While reset_i=0, SHALL force state IDLE, slv_sel_o=0, cpu_ready_o=0, cpu_err_o=0, cpu_rdata_o=0, slv_we_o=0 and cpu_reset_o=1.
REQ-026 Reset asserted mid-access SHALL abort the access in the next cycle with no response pulse.
REQ-027 cpu_reset_o SHALL power up as 1 and deassert exactly RESET_STRETCH cycles after the first clock with reset_i=1; the counter restarts on every reset_i=0.

Configuration
REQ-028 With BUS_TIMEOUT_EN defined, the ACCESS wait counter SHALL run.
- If slv_ready_i has not arrived after TIMEOUT_CYCLES cycles in ACCESS, go to RESP with cpu_err_o=1, cpu_rdata_o=0, and drop slv_sel_o.
REQ-029 Without BUS_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter logic SHALL be synthesised.

Structure
REQ-030 cpu_reg_package SHALL hold:
- the address map (get_address_start/get_address_end per slave enum);
- the bus_state_t enum (IDLE, ACCESS, RESP);
- num_entries, which sets NUM_SLAVES at instantiation.
REQ-031 The reset stretch SHALL be a sub-module reset_stretcher (clk_i, reset_i, RESET_STRETCH, reset_o).

Verification
REQ-032 Read test: slave 2 mapped 0x1000-0x1FFF, slv_ready_i[2]=1 immediately, read 0x1004 returning 0xDEADBEEF -> cpu_ready_o at N+2, cpu_rdata_o=0xDEADBEEF, cpu_err_o=0.
REQ-033 Unmapped test: read 0xFFFF0000 -> cpu_ready_o at N+1, cpu_err_o=1, cpu_rdata_o=0, slv_sel_o never nonzero.
REQ-034 Timeout test (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): slave never ready -> cpu_err_o=1 with ready at N+18; without the macro, no ready for 1000 cycles.
REQ-035 Write test: write 0xA5 with cpu_be_i=0001 to slave 0, ready delayed 3 cycles -> slv_we_o=1, slv_be_o=0001 and slv_sel_o=0x01 held 4 cycles, cpu_ready_o one cycle, cpu_rdata_o=0.
REQ-036 Reset test: reset_i=0 for 1 cycle during ACCESS -> no cpu_ready_o, state IDLE; cpu_reset_o high for exactly 5 cycles after release.
REQ-037 Overlap test: slaves 1 and 3 both cover 0x2000 -> slv_sel_o=0x02.
